// File: rtl/quad_encoder_emu.sv
// Quadrature rotary-encoder emulator.
// Each accepted step command produces one full A/B quadrature cycle
// (four transitions, 00 back to 00), optionally with contact bounce
// inserted after every real edge. A wrapping position counter tracks
// completed steps so the emulated shaft position can be compared with a
// decoder's count.
module quad_encoder_emu #(
  parameter int PHASE_CYCLES  = 16,
  parameter int BOUNCE_EDGES  = 3,
  parameter int BOUNCE_CYCLES = 2,
  parameter int POS_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 step_valid,
  input  logic                 step_dir,
  input  logic                 bounce_en,
  output logic                 step_ready,
  output logic                 enc_a,
  output logic                 enc_b,
  output logic                 busy,
  output logic [POS_WIDTH-1:0] position
);

  // One timer serves both hold lengths, so it is sized for the longer one.
  localparam int MAX_HOLD       = (PHASE_CYCLES > BOUNCE_CYCLES) ? PHASE_CYCLES : BOUNCE_CYCLES;
  localparam int TW             = $clog2(MAX_HOLD + 1);
  localparam int BOUNCE_TOGGLES = 2 * BOUNCE_EDGES;
  localparam int BW             = (BOUNCE_TOGGLES > 0) ? $clog2(BOUNCE_TOGGLES + 1) : 1;
  localparam bit HAS_BOUNCE     = (BOUNCE_EDGES > 0);

  // Terminal timer values: a level held N cycles changes on the edge where
  // the timer (cleared on the toggle edge) reads N-1.
  localparam logic [TW-1:0]        PC_LAST   = TW'(PHASE_CYCLES - 1);
  localparam logic [TW-1:0]        BC_LAST   = TW'(BOUNCE_CYCLES - 1);
  localparam logic [BW-1:0]        BCNT_LAST = BW'((BOUNCE_TOGGLES > 0) ? (BOUNCE_TOGGLES - 1) : 0);
  localparam logic [POS_WIDTH-1:0] POS_ONE   = POS_WIDTH'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDGE   = 2'd1,
    ST_BOUNCE = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [1:0]           trans_q, trans_d;
  logic                 dir_q, dir_d;
  logic                 bnc_q, bnc_d;
  logic                 enc_a_q, enc_a_d;
  logic                 enc_b_q, enc_b_d;
  logic [POS_WIDTH-1:0] pos_q, pos_d;
  logic                 ready_q;
  logic                 busy_q;

  logic                 accept_s;
  logic                 in_bounce_s;
  logic                 hold_done_s;
  logic [1:0]           next_idx_s;

  // Which line changes on transition idx: CW changes A on even transitions
  // (00->10, 11->01), CCW changes B on even transitions (00->01, 11->10).
  function automatic logic changes_a(input logic [1:0] idx, input logic cw);
    if (idx[0] == 1'b0) begin
      changes_a = cw;
    end else begin
      changes_a = ~cw;
    end
  endfunction

  // Next-state logic: handshake, bounce toggles, settle holds, completion.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bcnt_d   = bcnt_q;
    trans_d  = trans_q;
    dir_d    = dir_q;
    bnc_d    = bnc_q;
    enc_a_d  = enc_a_q;
    enc_b_d  = enc_b_q;
    pos_d    = pos_q;

    accept_s    = step_valid & ready_q;
    in_bounce_s = (state_q == ST_BOUNCE) | ((state_q == ST_EDGE) & bnc_q);
    next_idx_s  = trans_q + 2'd1;
    if (in_bounce_s) begin
      hold_done_s = (timer_q == BC_LAST);
    end else begin
      hold_done_s = (timer_q == PC_LAST);
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          // Transition 0 is registered on the accepting edge itself.
          dir_d   = step_dir;
          bnc_d   = bounce_en & HAS_BOUNCE;
          trans_d = 2'd0;
          bcnt_d  = {BW{1'b0}};
          timer_d = {TW{1'b0}};
          state_d = ST_EDGE;
          if (changes_a(2'd0, step_dir)) begin
            enc_a_d = ~enc_a_q;
          end else begin
            enc_b_d = ~enc_b_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      // EDGE marks the first cycle after a real toggle; from then on it
      // behaves like BOUNCE or SETTLE depending on the latched bounce mode,
      // which also covers holds of a single cycle.
      ST_EDGE, ST_BOUNCE, ST_SETTLE: begin
        if (!hold_done_s) begin
          timer_d = timer_q + TW'(1'b1);
          state_d = in_bounce_s ? ST_BOUNCE : ST_SETTLE;
        end else if (in_bounce_s) begin
          // Bounce toggle: the changing line flips back and forth; the
          // other line is never touched.
          timer_d = {TW{1'b0}};
          bcnt_d  = bcnt_q + BW'(1'b1);
          if (changes_a(trans_q, dir_q)) begin
            enc_a_d = ~enc_a_q;
          end else begin
            enc_b_d = ~enc_b_q;
          end
          if (bcnt_q == BCNT_LAST) begin
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_BOUNCE;
          end
        end else if (trans_q == 2'd3) begin
          // Fourth transition has settled: step complete, back at AB=00.
          timer_d = {TW{1'b0}};
          state_d = ST_IDLE;
          if (dir_q) begin
            pos_d = pos_q + POS_ONE;
          end else begin
            pos_d = pos_q - POS_ONE;
          end
        end else begin
          // Next real quadrature edge.
          timer_d = {TW{1'b0}};
          bcnt_d  = {BW{1'b0}};
          trans_d = next_idx_s;
          state_d = ST_EDGE;
          if (changes_a(next_idx_s, dir_q)) begin
            enc_a_d = ~enc_a_q;
          end else begin
            enc_b_d = ~enc_b_q;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any step in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= {TW{1'b0}};
      bcnt_q  <= {BW{1'b0}};
      trans_q <= 2'd0;
      dir_q   <= 1'b0;
      bnc_q   <= 1'b0;
      enc_a_q <= 1'b0;
      enc_b_q <= 1'b0;
      pos_q   <= {POS_WIDTH{1'b0}};
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bcnt_q  <= bcnt_d;
      trans_q <= trans_d;
      dir_q   <= dir_d;
      bnc_q   <= bnc_d;
      enc_a_q <= enc_a_d;
      enc_b_q <= enc_b_d;
      pos_q   <= pos_d;
      ready_q <= (state_d == ST_IDLE);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign step_ready = ready_q;
  assign busy       = busy_q;
  assign enc_a      = enc_a_q;
  assign enc_b      = enc_b_q;
  assign position   = pos_q;

endmodule

// File: tb/tb_quad_encoder_emu.sv
// Scoreboard bench for quad_encoder_emu: stimulus pushes the expected A/B
// edges (with their cycle numbers) and step completions into a queue; a
// monitor pops and compares whenever A/B changes or step_ready rises.
module tb_quad_encoder_emu;

  localparam int PC = 16;
  localparam int BE = 3;
  localparam int BC = 2;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          step_valid;
  logic          step_dir;
  logic          bounce_en;
  logic          step_ready;
  logic          enc_a;
  logic          enc_b;
  logic          busy;
  logic [PW-1:0] position;

  quad_encoder_emu #(
    .PHASE_CYCLES (PC),
    .BOUNCE_EDGES (BE),
    .BOUNCE_CYCLES(BC),
    .POS_WIDTH    (PW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .step_valid(step_valid),
    .step_dir  (step_dir),
    .bounce_en (bounce_en),
    .step_ready(step_ready),
    .enc_a     (enc_a),
    .enc_b     (enc_b),
    .busy      (busy),
    .position  (position)
  );

  always #5 clk = ~clk;

  // Posedge counter: after posedge number p, cyc reads p.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          done;
    logic [1:0]  ab;
    logic [7:0]  pos;
    int          at;
  } ev_t;

  ev_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  logic [7:0] exp_pos = 8'd0;
  logic [1:0] prev_ab;
  logic       prev_rdy;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_ab(input int t, input logic [1:0] v);
    ev_t e;
    e.done = 1'b0; e.ab = v; e.pos = 8'd0; e.at = t;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int t, input logic [7:0] p);
    ev_t e;
    e.done = 1'b1; e.ab = 2'b00; e.pos = p; e.at = t;
    exp_q.push_back(e);
  endtask

  // Expected waveform of one step accepted on posedge h.
  task automatic push_step(input int h, input bit cw, input bit bnc);
    logic [1:0] seq [4];
    logic [1:0] prev;
    logic [1:0] cur;
    int         t;
    if (cw) seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    else    seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    prev = 2'b00;
    t    = h;
    for (int k = 0; k < 4; k++) begin
      cur = seq[k];
      push_ab(t, cur);
      if (bnc) begin
        for (int j = 0; j < 2 * BE; j++) begin
          t += BC;
          push_ab(t, ((j % 2) == 0) ? prev : cur);
        end
      end
      t += PC;
      prev = cur;
    end
    exp_pos = cw ? exp_pos + 8'd1 : exp_pos - 8'd1;
    push_done(t, exp_pos);
  endtask

  task automatic observe(input bit done);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got done=%0d ab=%b pos=%0d at cycle %0d, required no event",
               done, {enc_a, enc_b}, position, cyc);
    end else begin
      e = exp_q.pop_front();
      if (done) begin
        if (!e.done || e.at != cyc || position !== e.pos) begin
          errors++;
          $display("FAIL sb_done: got ready-rise pos=%0d at cycle %0d, required done=%0d ab=%b pos=%0d at cycle %0d",
                   position, cyc, e.done, e.ab, e.pos, e.at);
        end
      end else begin
        if (e.done || e.at != cyc || {enc_a, enc_b} !== e.ab) begin
          errors++;
          $display("FAIL sb_ab: got ab=%b at cycle %0d, required done=%0d ab=%b pos=%0d at cycle %0d",
                   {enc_a, enc_b}, cyc, e.done, e.ab, e.pos, e.at);
        end
      end
    end
  endtask

  // Monitor: every A/B change and every step_ready rise is one DUT event.
  always @(negedge clk) begin
    if (mon_en) begin
      if ({enc_a, enc_b} !== prev_ab) observe(1'b0);
      if (step_ready === 1'b1 && prev_rdy === 1'b0) observe(1'b1);
    end
    prev_ab  <= {enc_a, enc_b};
    prev_rdy <= step_ready;
  end

  task automatic wait_ready(input int bound);
    int n = 0;
    while (step_ready !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (step_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: step_ready=%b after %0d cycles, required 1", step_ready, n);
    end
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d events outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic step_once(input bit cw, input bit bnc);
    int h;
    wait_ready(300);
    step_dir   = cw;
    bounce_en  = bnc;
    step_valid = 1'b1;
    h = cyc + 1;
    push_step(h, cw, bnc);
    @(negedge clk);
    step_valid = 1'b0;
    step_dir   = ~cw;
    bounce_en  = ~bnc;
    wait_drain(300);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int h;
    reset      = 1'b1;
    step_valid = 1'b0;
    step_dir   = 1'b0;
    bounce_en  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_enc_a", {7'd0, enc_a}, 8'd0);
    chk("rst_enc_b", {7'd0, enc_b}, 8'd0);
    chk("rst_ready", {7'd0, step_ready}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_position", position, 8'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {7'd0, step_ready}, 8'd1);
    chk("post_rst_busy", {7'd0, busy}, 8'd0);
    chk("post_rst_ab", {6'd0, enc_a, enc_b}, 8'd0);
    @(negedge clk);
    mon_en = 1'b1;

    // CCW with bounce: 4 x 28 cycles, position wraps 0 -> 255.
    step_once(1'b0, 1'b1);
    chk("ccw_pos_wrap", position, 8'd255);

    // CW without bounce: 4 x 16 cycles, position wraps 255 -> 0.
    step_once(1'b1, 1'b0);
    chk("cw_pos_wrap", position, 8'd0);

    // Back-to-back CW with step_valid held, plus ignored mid-step changes.
    step_dir   = 1'b1;
    bounce_en  = 1'b0;
    step_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_ready(200);
      h = cyc + 1;
      push_step(h, 1'b1, 1'b0);
      @(negedge clk);
      if (i == 2) step_valid = 1'b0;
      repeat (20) @(negedge clk);
      chk("b2b_busy_mid", {7'd0, busy}, 8'd1);
      step_dir   = 1'b0;
      bounce_en  = 1'b1;
      step_valid = 1'b1;
      repeat (5) @(negedge clk);
      step_dir   = 1'b1;
      bounce_en  = 1'b0;
      step_valid = (i != 2);
    end
    wait_drain(200);
    chk("b2b_position", position, 8'd3);

    // Reset during the third transition of a CCW step (AB=10 then).
    wait_ready(200);
    step_dir   = 1'b0;
    bounce_en  = 1'b0;
    step_valid = 1'b1;
    h = cyc + 1;
    push_step(h, 1'b0, 1'b0);
    @(negedge clk);
    step_valid = 1'b0;
    while (cyc < h + 40) @(negedge clk);
    chk("mid_ab_before_rst", {6'd0, enc_a, enc_b}, 8'd2);
    mon_en = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    chk("mid_rst_enc_a", {7'd0, enc_a}, 8'd0);
    chk("mid_rst_enc_b", {7'd0, enc_b}, 8'd0);
    chk("mid_rst_position", position, 8'd0);
    chk("mid_rst_busy", {7'd0, busy}, 8'd0);
    exp_q.delete();
    exp_pos = 8'd0;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rel_ready", {7'd0, step_ready}, 8'd1);
    chk("mid_rel_ab", {6'd0, enc_a, enc_b}, 8'd0);
    @(negedge clk);
    mon_en = 1'b1;

    // Normal operation resumes after the abandoned step.
    step_once(1'b1, 1'b1);
    chk("final_position", position, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/quad_encoder_emu.md
Name: quad_encoder_emu

Overview:
Quadrature rotary-encoder emulator: converts step commands into A/B quadrature waveforms, with optional contact bounce on each edge. It drives the encoder/debounce input path in simulation and in on-board self-test, standing in for a mechanical encoder. Step commands arrive on a valid/ready handshake. A running position counter lets the bench compare emulator position against the decoder's count.

Parameters:
PHASE_CYCLES, 16, cycles each settled quadrature state is held after its final edge (>=1)
BOUNCE_EDGES, 3, bounce pulse pairs after each real edge; 2*BOUNCE_EDGES extra toggles (>=0)
BOUNCE_CYCLES, 2, cycles each bounce level is held (>=1)
POS_WIDTH, 8, width of position counter

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
step_valid  input  1  step command valid
step_dir  input  1  1 = clockwise (A leads B), 0 = counter-clockwise
bounce_en  input  1  1 = insert bounce on every edge of this step
step_ready  output  1  emulator can accept a step
enc_a  output  1  quadrature channel A (registered)
enc_b  output  1  quadrature channel B (registered)
busy  output  1  step in progress
position  output  POS_WIDTH  signed-wrap count of completed steps

Behaviour:
- Clock is clk. Reset is synchronous and active-high.
- While reset is high: enc_a=0, enc_b=0, step_ready=0, busy=0, position=0, FSM=IDLE.
- Reset takes effect immediately when asserted mid-step. The step is abandoned and not counted. enc_a and enc_b return to 0 on the next edge.
- step_ready=1 in IDLE only; busy = !step_ready outside reset.
- Handshake: a step is accepted on the rising edge where step_valid & step_ready. step_dir and bounce_en are latched at that edge and ignored afterwards.
- One step is a full quadrature cycle of 4 transitions, starting and ending at AB=00:
  - CW: 00 -> 10 -> 11 -> 01 -> 00
  - CCW: 00 -> 01 -> 11 -> 10 -> 00
- Per-transition period: T = PHASE_CYCLES + (bounce ? 2*BOUNCE_EDGES*BOUNCE_CYCLES : 0).
- Transition k (k=0..3) is registered on the edge at handshake + k*T. The first change is visible the cycle after the accepting edge.
- Exactly one line changes per transition. The other line never glitches.
- Bounce sequence for a transition, when latched bounce=1 and BOUNCE_EDGES>0:
  - The changing line toggles to its new value, holds BOUNCE_CYCLES.
  - It then toggles old/new alternately, 2*BOUNCE_EDGES more toggles, each level held BOUNCE_CYCLES.
  - It ends at the new value, which is then held PHASE_CYCLES.
- FSM states:
  - IDLE -> EDGE on handshake.
  - EDGE: real toggle. Go to BOUNCE if bounce active, else SETTLE.
  - BOUNCE: toggle every BOUNCE_CYCLES until the extra-toggle count is exhausted, then SETTLE.
  - SETTLE: hold PHASE_CYCLES. Then EDGE if fewer than 4 transitions are done, else IDLE.
- Completion edge = handshake + 4T. On it:
  - position += 1 (CW) or -= 1 (CCW), modulo 2^POS_WIDTH (255+1=0, 0-1=255).
  - step_ready rises, visible the following cycle.
- Back-to-back: if step_valid is held high, the next step is accepted at handshake+4T+1. There is exactly 1 idle cycle at AB=00 between steps.
- Timers are sized for the larger of PHASE_CYCLES and BOUNCE_CYCLES. The counter terminal compares exactly (hold is N cycles, not N±1).
- step_valid while busy is ignored: no queueing, no effect on the current step.

Test Plan:
- Reset, then check outputs: enc_a=enc_b=0, position=0, step_ready=1 on the first cycle after reset falls.
- CW step, bounce_en=0, defaults -> AB sequence 10,11,01,00 with each state held 16 cycles; position=1; step_ready returns 1 at handshake+65.
- CCW step, bounce_en=1, defaults -> the first changing line is B. B toggles 7 times, 2 cycles apart, ending at 1. Each state settles 16 cycles; total step = 4*28 = 112 cycles. A is stable while B bounces. position=255 (wrap from 0).
- step_valid held high for 3 CW steps -> exactly 1 idle cycle at AB=00 between steps; position=3. Extra step_valid pulses mid-step are ignored.
- Reset asserted during the third transition of a step -> enc_a=enc_b=0 next cycle, position=0, step_ready=1 after release.
- Loopback through the team's debounce and encoder decoder, 10 CW steps with bounce_en=1 and PHASE_CYCLES >= 8 -> decoder count advances by the same amount as position.
